// File: rtl/uart_rx_frame_assembler_pkg.sv
// Shared constants and types for the UART receive path: bit timing, frame size,
// parity encoding and the byte-receiver state encoding.
package uart_rx_frame_assembler_pkg;

   localparam int UART_CLKS_PER_BIT = 27;
   localparam int FRAME_BYTES       = 14;
   localparam int UART_TIMEOUT_CLKS = 4000;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   // Even parity sends the XOR of the data bits, odd parity sends its complement.
   function automatic logic expected_parity(input logic [7:0] data, input logic parity_type);
      return (^data) ^ (parity_type == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single-character UART receiver: 2-flop synchroniser plus a start/data/parity/stop
// bit FSM that emits one byte_valid pulse per character with a combined error flag.
module uart_rx_byte
   import uart_rx_frame_assembler_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic       clk_3125,
   input  logic       rst,
   input  logic       rx,
   input  logic       parity_type,
   output logic [7:0] data_byte,
   output logic       byte_valid,
   output logic       byte_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_t        state;
   rx_state_t        state_next;
   logic             rx_meta;
   logic             rx_sync;
   logic             rx_prev;
   logic             falling_edge;
   logic             sample_tick;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_q;
   logic             parity_err;

   always_ff @(posedge clk_3125) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign falling_edge = rx_prev & ~rx_sync;

   always_ff @(posedge clk_3125) begin
      if (rst) begin
         state <= RX_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A high sample at mid start bit is a glitch, not a character.
   always_comb begin
      state_next = state;
      unique case (state)
         RX_IDLE:   if (falling_edge) state_next = RX_START;
         RX_START:  if (sample_tick) state_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:   if (sample_tick && bit_idx == 3'd7) state_next = RX_PARITY;
         RX_PARITY: if (sample_tick) state_next = RX_STOP;
         RX_STOP:   if (sample_tick) state_next = RX_IDLE;
         default:   state_next = RX_IDLE;
      endcase
   end

   always_comb begin
      sample_tick = 1'b0;
      unique case (state)
         RX_START:                   sample_tick = (clk_cnt == HALF_LAST);
         RX_DATA, RX_PARITY, RX_STOP: sample_tick = (clk_cnt == BIT_LAST);
         default:                    sample_tick = 1'b0;
      endcase
   end

   always_ff @(posedge clk_3125) begin
      if (rst) begin
         clk_cnt    <= '0;
         bit_idx    <= '0;
         shift_q    <= '0;
         parity_err <= 1'b0;
         data_byte  <= '0;
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         clk_cnt    <= (state == RX_IDLE || sample_tick) ? '0 : clk_cnt + 1'b1;
         unique case (state)
            RX_IDLE: begin
               bit_idx    <= '0;
               parity_err <= 1'b0;
            end
            RX_DATA: begin
               if (sample_tick) begin
                  shift_q <= {rx_sync, shift_q[7:1]};
                  bit_idx <= bit_idx + 3'd1;
               end
            end
            RX_PARITY: begin
               if (sample_tick) parity_err <= (rx_sync != expected_parity(shift_q, parity_type));
            end
            RX_STOP: begin
               if (sample_tick) begin
                  data_byte  <= shift_q;
                  byte_err   <= parity_err | ~rx_sync;
                  byte_valid <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_frame_assembler.sv
// Collects 14 received UART bytes into one parallel frame with a one-cycle frame_valid;
// partial frames are dropped after a long idle gap or on reset.
module uart_rx_frame_assembler
   import uart_rx_frame_assembler_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int TIMEOUT_CLKS = UART_TIMEOUT_CLKS
) (
   input  logic       clk_3125,
   input  logic       rst,
   input  logic       rx,
   input  logic       parity_type,
   output logic [7:0] data0,
   output logic [7:0] data1,
   output logic [7:0] data2,
   output logic [7:0] data3,
   output logic [7:0] data4,
   output logic [7:0] data5,
   output logic [7:0] data6,
   output logic [7:0] data7,
   output logic [7:0] data8,
   output logic [7:0] data9,
   output logic [7:0] data10,
   output logic [7:0] data11,
   output logic [7:0] data12,
   output logic [7:0] data13,
   output logic       frame_valid,
   output logic       frame_err,
   output logic [3:0] byte_count
);

   localparam logic [3:0]  LAST_IDX    = 4'(FRAME_BYTES - 1);
   localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CLKS);

   logic [7:0]  rx_byte;
   logic        rx_byte_valid;
   logic        rx_byte_err;
   logic [7:0]  slot   [FRAME_BYTES];
   logic [7:0]  data_q [FRAME_BYTES];
   logic        err_acc;
   logic        frame_pending;
   logic [15:0] idle_cnt;
   logic        timeout_fire;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx_byte (
      .clk_3125    (clk_3125),
      .rst         (rst),
      .rx          (rx),
      .parity_type (parity_type),
      .data_byte   (rx_byte),
      .byte_valid  (rx_byte_valid),
      .byte_err    (rx_byte_err)
   );

   // A byte arriving in the same cycle as the timeout takes priority.
   assign timeout_fire = (byte_count != 4'd0) && !rx_byte_valid && (idle_cnt == TIMEOUT_VAL);

   always_ff @(posedge clk_3125) begin
      if (rst || rx_byte_valid || byte_count == 4'd0 || timeout_fire) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 16'd1;
      end
   end

   // The last byte lands in its slot first; the whole frame is published one cycle later.
   always_ff @(posedge clk_3125) begin
      if (rst) begin
         byte_count    <= '0;
         err_acc       <= 1'b0;
         frame_pending <= 1'b0;
         frame_valid   <= 1'b0;
         frame_err     <= 1'b0;
         for (int i = 0; i < FRAME_BYTES; i++) begin
            slot[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         frame_valid <= 1'b0;
         if (frame_pending) begin
            for (int i = 0; i < FRAME_BYTES; i++) data_q[i] <= slot[i];
            frame_err     <= err_acc;
            frame_valid   <= 1'b1;
            frame_pending <= 1'b0;
            byte_count    <= '0;
            err_acc       <= 1'b0;
         end else if (rx_byte_valid) begin
            slot[byte_count] <= rx_byte;
            err_acc          <= err_acc | rx_byte_err;
            if (byte_count == LAST_IDX) begin
               frame_pending <= 1'b1;
            end else begin
               byte_count <= byte_count + 4'd1;
            end
         end else if (timeout_fire) begin
            byte_count <= '0;
            err_acc    <= 1'b0;
         end
      end
   end

   assign data0  = data_q[0];
   assign data1  = data_q[1];
   assign data2  = data_q[2];
   assign data3  = data_q[3];
   assign data4  = data_q[4];
   assign data5  = data_q[5];
   assign data6  = data_q[6];
   assign data7  = data_q[7];
   assign data8  = data_q[8];
   assign data9  = data_q[9];
   assign data10 = data_q[10];
   assign data11 = data_q[11];
   assign data12 = data_q[12];
   assign data13 = data_q[13];

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Scoreboard bench: serialises bytes onto rx, queues the expected frame, and checks
// every frame_valid against the queue head.
module tb_uart_rx_frame_assembler;

   localparam int BIT_CLKS = 27;

   typedef struct packed {
      logic [111:0] bytes;
      logic         err;
   } frame_t;

   logic       clk_3125;
   logic       rst;
   logic       rx;
   logic       parity_type;
   logic [7:0] dout [14];
   logic       frame_valid;
   logic       frame_err;
   logic [3:0] byte_count;

   frame_t exp_q[$];
   frame_t mon_frame;
   int     compared;
   int     mismatched;
   int     frames_seen;

   uart_rx_frame_assembler dut (
      .clk_3125    (clk_3125),
      .rst         (rst),
      .rx          (rx),
      .parity_type (parity_type),
      .data0       (dout[0]),
      .data1       (dout[1]),
      .data2       (dout[2]),
      .data3       (dout[3]),
      .data4       (dout[4]),
      .data5       (dout[5]),
      .data6       (dout[6]),
      .data7       (dout[7]),
      .data8       (dout[8]),
      .data9       (dout[9]),
      .data10      (dout[10]),
      .data11      (dout[11]),
      .data12      (dout[12]),
      .data13      (dout[13]),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .byte_count  (byte_count)
   );

   initial clk_3125 = 1'b0;
   always #5 clk_3125 = ~clk_3125;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // One 11-bit character: start, 8 data LSB first, parity, stop, then a short idle gap.
   task automatic applyStimulus(input logic [7:0] b, input logic tx_ptype, input bit flip, input logic stop_val);
      logic [10:0] bits;
      bits = {stop_val, (^b) ^ tx_ptype ^ flip, b, 1'b0};
      for (int k = 0; k < 11; k++) begin
         rx = bits[k];
         repeat (BIT_CLKS) @(negedge clk_3125);
      end
      rx = 1'b1;
      repeat (10) @(negedge clk_3125);
   endtask

   task automatic sendFrame(input logic [7:0] base, input bit incr, input logic tx_ptype,
                            input int flip_idx, input int stop_low_idx);
      frame_t     f;
      logic [7:0] b;
      f = '0;
      for (int i = 0; i < 14; i++) begin
         b = incr ? base + 8'(i) : base;
         f.bytes[i*8 +: 8] = b;
         if (i == flip_idx || i == stop_low_idx || tx_ptype != parity_type) f.err = 1'b1;
      end
      exp_q.push_back(f);
      for (int i = 0; i < 14; i++) begin
         b = incr ? base + 8'(i) : base;
         applyStimulus(b, tx_ptype, i == flip_idx, (i == stop_low_idx) ? 1'b0 : 1'b1);
      end
   endtask

   always @(negedge clk_3125) begin
      if (frame_valid) begin
         frames_seen++;
         if (exp_q.size() == 0) begin
            checkOutput("unexpected frame_valid", 32'd1, 32'd0);
         end else begin
            mon_frame = exp_q.pop_front();
            for (int i = 0; i < 14; i++) begin
               checkOutput($sformatf("frame%0d data%0d", frames_seen, i), 32'(dout[i]),
                           32'(mon_frame.bytes[i*8 +: 8]));
            end
            checkOutput($sformatf("frame%0d frame_err", frames_seen), 32'(frame_err), 32'(mon_frame.err));
         end
      end
   end

   initial begin
      compared    = 0;
      mismatched  = 0;
      frames_seen = 0;
      rx          = 1'b1;
      rst         = 1'b1;
      parity_type = 1'b0;
      repeat (5) @(negedge clk_3125);
      rst = 1'b0;
      @(negedge clk_3125);

      checkOutput("reset frame_valid", 32'(frame_valid), 32'd0);
      checkOutput("reset frame_err", 32'(frame_err), 32'd0);
      checkOutput("reset byte_count", 32'(byte_count), 32'd0);
      checkOutput("reset data0", 32'(dout[0]), 32'd0);
      checkOutput("reset data13", 32'(dout[13]), 32'd0);

      sendFrame(8'h00, 1'b1, 1'b0, -1, -1);
      checkOutput("loopback byte_count", 32'(byte_count), 32'd0);

      sendFrame(8'h20, 1'b1, 1'b0, 5, -1);
      sendFrame(8'h10, 1'b1, 1'b0, -1, -1);

      parity_type = 1'b1;
      sendFrame(8'hA5, 1'b0, 1'b1, -1, -1);
      parity_type = 1'b0;
      sendFrame(8'hA5, 1'b0, 1'b1, -1, -1);

      for (int i = 0; i < 7; i++) applyStimulus(8'h60 + 8'(i), 1'b0, 1'b0, 1'b1);
      checkOutput("partial byte_count", 32'(byte_count), 32'd7);
      repeat (4100) @(negedge clk_3125);
      checkOutput("timeout byte_count", 32'(byte_count), 32'd0);
      checkOutput("timeout frames_seen", 32'(frames_seen), 32'd5);
      checkOutput("timeout hold data0", 32'(dout[0]), 32'hA5);
      sendFrame(8'h40, 1'b1, 1'b0, -1, -1);
      checkOutput("after timeout frames_seen", 32'(frames_seen), 32'd6);

      rx = 1'b0;
      repeat (5) @(negedge clk_3125);
      rx = 1'b1;
      repeat (60) @(negedge clk_3125);
      checkOutput("glitch byte_count", 32'(byte_count), 32'd0);
      checkOutput("glitch frames_seen", 32'(frames_seen), 32'd6);
      sendFrame(8'h50, 1'b1, 1'b0, -1, 13);

      for (int i = 0; i < 9; i++) applyStimulus(8'h70 + 8'(i), 1'b0, 1'b0, 1'b1);
      checkOutput("pre-reset byte_count", 32'(byte_count), 32'd9);
      rst = 1'b1;
      @(negedge clk_3125);
      rst = 1'b0;
      @(negedge clk_3125);
      checkOutput("mid-frame reset byte_count", 32'(byte_count), 32'd0);
      checkOutput("mid-frame reset data0", 32'(dout[0]), 32'd0);
      checkOutput("mid-frame reset frame_err", 32'(frame_err), 32'd0);
      sendFrame(8'h80, 1'b1, 1'b0, -1, -1);

      for (int w = 0; w < 1000 && exp_q.size() != 0; w++) @(negedge clk_3125);
      checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
      repeat (20) @(negedge clk_3125);
      checkOutput("total frames", 32'(frames_seen), 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
